// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the IF/MEM memory bus arbiter.
// Stall vector indices and polarity match the pipeline stall controller.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'b00,
        ARB_BUS_MEM = 2'b01,
        ARB_BUS_IF  = 2'b10
    } arb_state_t;

    localparam logic [2:0] STALL_IF_IDX  = 3'd1;
    localparam logic [2:0] STALL_MEM_IDX = 3'd4;
    localparam logic       STOP          = 1'b1;

    // A stage advances at the next edge when its hold bit is not asserted.
    function automatic logic stage_advances(input logic [5:0] stall, input logic [2:0] idx);
        return stall[idx] != STOP;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_port.sv
// Per-requester bookkeeping: remembers a served word until the owning stage
// advances, and produces that requester's stall request and read data.
module mem_arb_port
    import mem_bus_arbiter_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              grant,
    input  logic              ack,
    input  logic              advance,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              done,
    output logic              stallreq,
    output logic [DATA_W-1:0] rdata
);

    logic              served;
    logic [DATA_W-1:0] rdata_q;

    assign served = grant && ack;

    // A frozen stage keeps seeing its word without another bus cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            done    <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (served) begin
                rdata_q <= bus_rdata;
                done    <= !advance;
            end else if (advance) begin
                done    <= 1'b0;
            end
        end
    end

    assign stallreq = req && !done && !served;
    assign rdata    = served ? bus_rdata : rdata_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter for the shared multi-cycle memory bus; MEM has fixed
// priority over IF and every transaction is followed by one IDLE cycle.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_stallreq_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [3:0]        mem_sel_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_stallreq_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [3:0]        bus_sel_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic [DATA_W-1:0] bus_rdata_i,
    input  logic              bus_ack_i
);

    arb_state_t state;
    logic       if_done;
    logic       mem_done;
    logic       if_grant;
    logic       mem_grant;
    logic       if_advance;
    logic       mem_advance;

    assign if_grant    = (state == ARB_BUS_IF);
    assign mem_grant   = (state == ARB_BUS_MEM);
    assign if_advance  = stage_advances(stall_i, STALL_IF_IDX);
    assign mem_advance = stage_advances(stall_i, STALL_MEM_IDX);

    // Bus outputs are registered copies loaded on the grant edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ARB_IDLE;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_sel_o   <= '0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (mem_req_i && !mem_done) begin
                        state       <= ARB_BUS_MEM;
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= mem_we_i;
                        bus_sel_o   <= mem_sel_i;
                        bus_addr_o  <= mem_addr_i;
                        bus_wdata_o <= mem_wdata_i;
                    end else if (if_req_i && !if_done) begin
                        state       <= ARB_BUS_IF;
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= 1'b0;
                        bus_sel_o   <= 4'hF;
                        bus_addr_o  <= if_addr_i;
                        bus_wdata_o <= '0;
                    end
                end
                ARB_BUS_MEM, ARB_BUS_IF: begin
                    if (bus_ack_i) begin
                        state     <= ARB_IDLE;
                        bus_req_o <= 1'b0;
                    end
                end
                default: begin
                    state     <= ARB_IDLE;
                    bus_req_o <= 1'b0;
                end
            endcase
        end
    end

    mem_arb_port #(.DATA_W(DATA_W)) u_if_port (
        .clk       (clk),
        .rst       (rst),
        .req       (if_req_i),
        .grant     (if_grant),
        .ack       (bus_ack_i),
        .advance   (if_advance),
        .bus_rdata (bus_rdata_i),
        .done      (if_done),
        .stallreq  (if_stallreq_o),
        .rdata     (if_rdata_o)
    );

    mem_arb_port #(.DATA_W(DATA_W)) u_mem_port (
        .clk       (clk),
        .rst       (rst),
        .req       (mem_req_i),
        .grant     (mem_grant),
        .ack       (bus_ack_i),
        .advance   (mem_advance),
        .bus_rdata (bus_rdata_i),
        .done      (mem_done),
        .stallreq  (mem_stallreq_o),
        .rdata     (mem_rdata_o)
    );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: a wait-state bus slave answers from a
// word memory model and each served access is checked against queued expectations.
module tb_mem_bus_arbiter;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    typedef struct {
        logic              is_if;
        logic              is_store;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [5:0]        stall_i;
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic [DATA_W-1:0] if_rdata_o;
    logic              if_stallreq_o;
    logic              mem_req_i;
    logic              mem_we_i;
    logic [3:0]        mem_sel_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [DATA_W-1:0] mem_wdata_i;
    logic [DATA_W-1:0] mem_rdata_o;
    logic              mem_stallreq_o;
    logic              bus_req_o;
    logic              bus_we_o;
    logic [3:0]        bus_sel_o;
    logic [ADDR_W-1:0] bus_addr_o;
    logic [DATA_W-1:0] bus_wdata_o;
    logic [DATA_W-1:0] bus_rdata_i;
    logic              bus_ack_i;

    logic [DATA_W-1:0] mem_model [0:1023];
    exp_t              sb [$];
    int                wait_n;
    int                wait_cnt;
    int                errors;
    int                checks;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall_i),
        .if_req_i       (if_req_i),
        .if_addr_i      (if_addr_i),
        .if_rdata_o     (if_rdata_o),
        .if_stallreq_o  (if_stallreq_o),
        .mem_req_i      (mem_req_i),
        .mem_we_i       (mem_we_i),
        .mem_sel_i      (mem_sel_i),
        .mem_addr_i     (mem_addr_i),
        .mem_wdata_i    (mem_wdata_i),
        .mem_rdata_o    (mem_rdata_o),
        .mem_stallreq_o (mem_stallreq_o),
        .bus_req_o      (bus_req_o),
        .bus_we_o       (bus_we_o),
        .bus_sel_o      (bus_sel_o),
        .bus_addr_o     (bus_addr_o),
        .bus_wdata_o    (bus_wdata_o),
        .bus_rdata_i    (bus_rdata_i),
        .bus_ack_i      (bus_ack_i)
    );

    // Mid-cycle: slave answers, outputs settle, scoreboard consumes any ack.
    task automatic settle();
        exp_t        e;
        logic [31:0] got;
        @(negedge clk);
        bus_ack_i   = (bus_req_o === 1'b1) && (wait_cnt == wait_n);
        bus_rdata_i = bus_ack_i ? mem_model[bus_addr_o[11:2]] : 32'hA5A5_A5A5;
        #1;
        if (bus_ack_i && !rst) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow: unexpected ack at addr %h", bus_addr_o);
            end else begin
                e = sb.pop_front();
                if (bus_addr_o !== e.addr) begin
                    errors++;
                    $display("FAIL sb_addr: got %h expected %h", bus_addr_o, e.addr);
                end
                if (e.is_store) begin
                    for (int b = 0; b < 4; b++)
                        if (bus_sel_o[b]) mem_model[bus_addr_o[11:2]][8*b +: 8] = bus_wdata_o[8*b +: 8];
                end else begin
                    checks++;
                    got = e.is_if ? if_rdata_o : mem_rdata_o;
                    if (got !== e.data) begin
                        errors++;
                        $display("FAIL sb_rdata(%s @%h): got %h expected %h",
                                 e.is_if ? "if" : "mem", e.addr, got, e.data);
                    end
                end
            end
        end
    endtask

    // Close the cycle: update the slave wait counter and cross the clock edge.
    task automatic adv();
        if (bus_req_o === 1'b1 && bus_ack_i !== 1'b1) wait_cnt++;
        else wait_cnt = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic is_if, input logic is_store, input logic [ADDR_W-1:0] a);
        exp_t e;
        e.is_if    = is_if;
        e.is_store = is_store;
        e.addr     = a;
        e.data     = mem_model[a[11:2]];
        sb.push_back(e);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        adv();
        adv();
        settle();
        checks += 8;
        if (bus_req_o !== 1'b0)      begin errors++; $display("FAIL rst_bus_req: got %b expected 0", bus_req_o); end
        if (bus_we_o !== 1'b0)       begin errors++; $display("FAIL rst_bus_we: got %b expected 0", bus_we_o); end
        if (bus_sel_o !== 4'h0)      begin errors++; $display("FAIL rst_bus_sel: got %h expected 0", bus_sel_o); end
        if (bus_addr_o !== '0)       begin errors++; $display("FAIL rst_bus_addr: got %h expected 0", bus_addr_o); end
        if (bus_wdata_o !== '0)      begin errors++; $display("FAIL rst_bus_wdata: got %h expected 0", bus_wdata_o); end
        if (if_rdata_o !== '0)       begin errors++; $display("FAIL rst_if_rdata: got %h expected 0", if_rdata_o); end
        if (mem_rdata_o !== '0)      begin errors++; $display("FAIL rst_mem_rdata: got %h expected 0", mem_rdata_o); end
        if ({if_stallreq_o, mem_stallreq_o} !== 2'b00) begin
            errors++; $display("FAIL rst_stallreq: got %b expected 00", {if_stallreq_o, mem_stallreq_o});
        end
        adv();
        rst = 1'b0;
        adv();
    endtask

    task automatic test_mem_load();
        int  nreq = 0, nstall = 0;
        bit  fin = 0;
        wait_n = 0;
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF; mem_addr_i = 12'h010;
        push(1'b0, 1'b0, 12'h010);
        for (int c = 0; c < 8 && !fin; c++) begin
            settle();
            if (bus_req_o) nreq++;
            if (mem_stallreq_o) nstall++;
            if (!mem_stallreq_o) fin = 1;
            adv();
        end
        mem_req_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            settle();
            if (bus_req_o) nreq++;
            adv();
        end
        checks += 3;
        if (!fin)        begin errors++; $display("FAIL load_timeout: got no completion expected completion"); end
        if (nreq != 1)   begin errors++; $display("FAIL load_bus_cycles: got %0d expected 1", nreq); end
        if (nstall != 1) begin errors++; $display("FAIL load_stall_cycles: got %0d expected 1", nstall); end
    endtask

    task automatic test_priority();
        int  if_stall = 0, mem_fin = -1, if_fin = -1, nbus = 0;
        int  first_bus = -1, last_bus = -1;
        logic [ADDR_W-1:0] first_addr = '0;
        wait_n = 2;
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF; mem_addr_i = 12'h020;
        if_req_i  = 1'b1; if_addr_i = 12'h080;
        push(1'b0, 1'b0, 12'h020);
        push(1'b1, 1'b0, 12'h080);
        for (int c = 0; c < 20 && if_fin < 0; c++) begin
            settle();
            if (if_stallreq_o) if_stall++;
            if (bus_req_o) begin
                if (first_bus < 0) begin first_bus = c; first_addr = bus_addr_o; end
                last_bus = c;
                nbus++;
            end
            if (mem_req_i && !mem_stallreq_o) mem_fin = c;
            if (if_req_i && !if_stallreq_o) if_fin = c;
            adv();
            if (mem_fin >= 0) mem_req_i = 1'b0;
        end
        if_req_i = 1'b0;
        checks += 5;
        if (first_addr !== 12'h020) begin errors++; $display("FAIL prio_first_addr: got %h expected 020", first_addr); end
        if (mem_fin != 3)  begin errors++; $display("FAIL prio_mem_done_cycle: got %0d expected 3", mem_fin); end
        if (if_fin != 7)   begin errors++; $display("FAIL prio_if_done_cycle: got %0d expected 7", if_fin); end
        if (if_stall != 7) begin errors++; $display("FAIL prio_if_stall_cycles: got %0d expected 7", if_stall); end
        if ((last_bus - first_bus + 1) - nbus != 1) begin
            errors++; $display("FAIL prio_idle_gap: got %0d expected 1", (last_bus - first_bus + 1) - nbus);
        end
        settle();
        adv();
    endtask

    task automatic test_store();
        int nstall = 0;
        bit fin = 0;
        wait_n = 3;
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = 4'b0011;
        mem_addr_i = 12'h030; mem_wdata_i = 32'h1234_5678;
        push(1'b0, 1'b1, 12'h030);
        for (int c = 0; c < 12 && !fin; c++) begin
            settle();
            if (mem_stallreq_o) nstall++;
            if (bus_req_o) begin
                checks++;
                if ({bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o} !== {1'b1, 4'b0011, 12'h030, 32'h1234_5678}) begin
                    errors++;
                    $display("FAIL store_bus_hold c%0d: got we=%b sel=%b addr=%h wdata=%h expected we=1 sel=0011 addr=030 wdata=12345678",
                             c, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o);
                end
            end
            if (!mem_stallreq_o) begin
                fin = 1;
                checks++;
                if (bus_ack_i !== 1'b1) begin errors++; $display("FAIL store_stall_fall: ack got %b expected 1", bus_ack_i); end
            end
            adv();
            if (bus_req_o) begin
                mem_wdata_i = 32'hFFFF_FFFF;
                mem_addr_i  = 12'hFFC;
            end
        end
        mem_req_i = 1'b0; mem_we_i = 1'b0; mem_wdata_i = '0;
        checks += 2;
        if (!fin)        begin errors++; $display("FAIL store_timeout: got no completion expected completion"); end
        if (nstall != 4) begin errors++; $display("FAIL store_stall_cycles: got %0d expected 4", nstall); end
        settle();
        adv();
    endtask

    task automatic test_if_hold();
        bit fin = 0;
        wait_n = 0;
        if_req_i = 1'b1; if_addr_i = 12'h040;
        push(1'b1, 1'b0, 12'h040);
        settle();
        checks++;
        if (if_stallreq_o !== 1'b1) begin errors++; $display("FAIL hold_req_stall: got %b expected 1", if_stallreq_o); end
        adv();
        stall_i[1] = 1'b1;
        settle();
        checks++;
        if (if_stallreq_o !== 1'b0) begin errors++; $display("FAIL hold_ack_stall: got %b expected 0", if_stallreq_o); end
        adv();
        for (int c = 0; c < 5; c++) begin
            if (c == 4) stall_i[1] = 1'b0;
            settle();
            checks += 3;
            if (bus_req_o !== 1'b0)   begin errors++; $display("FAIL hold_bus_req c%0d: got %b expected 0", c, bus_req_o); end
            if (if_stallreq_o !== 1'b0) begin errors++; $display("FAIL hold_stallreq c%0d: got %b expected 0", c, if_stallreq_o); end
            if (if_rdata_o !== 32'h0000_0013) begin
                errors++; $display("FAIL hold_rdata c%0d: got %h expected 00000013", c, if_rdata_o);
            end
            adv();
        end
        if_addr_i = 12'h044;
        push(1'b1, 1'b0, 12'h044);
        settle();
        checks++;
        if (if_stallreq_o !== 1'b1) begin errors++; $display("FAIL hold_done_clear: got %b expected 1", if_stallreq_o); end
        adv();
        for (int c = 0; c < 6 && !fin; c++) begin
            settle();
            if (!if_stallreq_o) fin = 1;
            adv();
        end
        if_req_i = 1'b0;
        checks++;
        if (!fin) begin errors++; $display("FAIL hold_next_timeout: got no completion expected completion"); end
        settle();
        adv();
    endtask

    task automatic test_reset_mid();
        wait_n = 0;
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF; mem_addr_i = 12'h010;
        settle();
        adv();
        rst = 1'b1;
        settle();
        checks++;
        if ({bus_req_o, bus_ack_i} !== 2'b11) begin
            errors++; $display("FAIL rmid_setup: got req/ack=%b expected 11", {bus_req_o, bus_ack_i});
        end
        adv();
        rst = 1'b0;
        mem_req_i = 1'b0;
        settle();
        checks += 3;
        if (bus_req_o !== 1'b0)  begin errors++; $display("FAIL rmid_bus_req: got %b expected 0", bus_req_o); end
        if (mem_rdata_o !== '0)  begin errors++; $display("FAIL rmid_rdata: got %h expected 0", mem_rdata_o); end
        if (if_rdata_o !== '0)   begin errors++; $display("FAIL rmid_if_rdata: got %h expected 0", if_rdata_o); end
        adv();
        settle();
        checks++;
        if (bus_req_o !== 1'b0)  begin errors++; $display("FAIL rmid_idle: got %b expected 0", bus_req_o); end
        adv();
    endtask

    task automatic test_back_to_back();
        int   idx = 0, ncyc = 0;
        logic hist [0:11];
        wait_n = 0;
        for (int c = 0; c < 12; c++) hist[c] = 1'b0;
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF; mem_addr_i = 12'h100;
        push(1'b0, 1'b0, 12'h100);
        for (int c = 0; c < 12 && idx < 2; c++) begin
            settle();
            hist[c] = bus_req_o;
            ncyc = c + 1;
            if (mem_req_i && !mem_stallreq_o) begin
                idx++;
                adv();
                if (idx < 2) begin
                    mem_addr_i = 12'h104;
                    push(1'b0, 1'b0, 12'h104);
                end else begin
                    mem_req_i = 1'b0;
                end
            end else begin
                adv();
            end
        end
        checks += 2;
        if (ncyc != 4) begin errors++; $display("FAIL b2b_cycles: got %0d expected 4", ncyc); end
        if ({hist[0], hist[1], hist[2], hist[3]} !== 4'b0101) begin
            errors++; $display("FAIL b2b_pattern: got %b expected 0101", {hist[0], hist[1], hist[2], hist[3]});
        end
        settle();
        adv();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        wait_n = 0;
        wait_cnt = 0;
        for (int i = 0; i < 1024; i++) mem_model[i] = 32'h5A00_0000 ^ (i * 32'h0001_0101);
        mem_model[12'h010 >> 2] = 32'hDEAD_BEEF;
        mem_model[12'h020 >> 2] = 32'hCAFE_F00D;
        mem_model[12'h040 >> 2] = 32'h0000_0013;
        mem_model[12'h080 >> 2] = 32'h0010_0093;
        mem_model[12'h100 >> 2] = 32'h1111_1111;
        mem_model[12'h104 >> 2] = 32'h2222_2222;
        rst = 1'b1;
        stall_i = '0;
        if_req_i = 1'b0; if_addr_i = '0;
        mem_req_i = 1'b0; mem_we_i = 1'b0; mem_sel_i = '0; mem_addr_i = '0; mem_wdata_i = '0;
        bus_rdata_i = '0; bus_ack_i = 1'b0;

        test_reset();
        test_mem_load();
        test_priority();
        test_store();
        test_if_hold();
        test_reset_mid();
        test_back_to_back();

        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d expected 0", sb.size()); end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
